// File: rtl/cpu_sequencer.sv
// ============================================================================
// cpu_sequencer
// ----------------------------------------------------------------------------
// Instruction sequencer for the PLC CPU. It runs IEC 61131 style scan cycles
// over Program Memory. Each scan runs the IL instructions at addresses 0
// through prog_last. Every instruction takes three clocks:
//   FETCH  : pm_addr = pc. The synchronous ROM returns the word next clock.
//   DECODE : the PM fields are latched toward the ALU/DM and dm_rd is pulsed.
//   EXEC   : the ALU result is valid combinationally. The write strobes for
//            Data Memory and the Current Result register are raised here.
// After the last instruction, the DONE state pulses scan_done and advances
// scan_cnt. It then either starts the next scan at once (run=1) or returns to
// IDLE (run=0).
//
// Instruction code map, shared with the ALU:
//   01 LD     02 LDN    03 LDI    04 ST     05 STN    06 S      07 R
//   08 AND    09 ANDN   0A ANDI   0B OR     0C ORN    0D ORI    0E XOR
//   0F XORN   10 XORI   11 NOT    12 EQU    13 F_TRIG 14 R_TRIG
//   Any other code is undefined. It raises op_err and is executed as a NOP.
//
// Ports
//   clk           in   1          system clock, rising edge
//   rst           in   1          synchronous reset, active-high
//   run           in   1          run scans; sampled only in IDLE and DONE
//   prog_last     in   PM_ADDR_W  last instruction address; latched at scan start
//   pm_addr       out  PM_ADDR_W  Program Memory address
//   pm_instr_code in   8          instruction code field of the PM word
//   pm_dm_type    in   2          DM access type field (BIT/BYTE/WORD/DWORD)
//   pm_dm_addr    in   DM_ADDR_W  DM operand address field
//   pm_const      in   32         immediate field (routed to the ALU elsewhere)
//   cr_out        in   32         current CR value; bit 0 gates R and S
//   instr_code    out  8          latched instruction code to the ALU
//   dm_type       out  2          latched access type to the ALU/DM
//   dm_addr       out  DM_ADDR_W  latched DM address
//   dm_rd         out  1          DM read strobe (DECODE)
//   dm_we         out  1          DM write enable (EXEC)
//   cr_we         out  1          CR write enable (EXEC)
//   busy          out  1          high whenever not IDLE
//   scan_done     out  1          one-clock pulse in DONE
//   scan_cnt      out  16         completed scan counter, wraps to 0
//   op_err        out  1          one-clock pulse in EXEC for an undefined code
// ============================================================================
module cpu_sequencer #(
    parameter int DM_ADDR_W = 8,
    parameter int PM_ADDR_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    input  logic [PM_ADDR_W-1:0] prog_last,
    output logic [PM_ADDR_W-1:0] pm_addr,
    input  logic [7:0]           pm_instr_code,
    input  logic [1:0]           pm_dm_type,
    input  logic [DM_ADDR_W-1:0] pm_dm_addr,
    input  logic [31:0]          pm_const,
    input  logic [31:0]          cr_out,
    output logic [7:0]           instr_code,
    output logic [1:0]           dm_type,
    output logic [DM_ADDR_W-1:0] dm_addr,
    output logic                 dm_rd,
    output logic                 dm_we,
    output logic                 cr_we,
    output logic                 busy,
    output logic                 scan_done,
    output logic [15:0]          scan_cnt,
    output logic                 op_err
);

    // ------------------------------------------------------------------
    // Instruction codes
    // ------------------------------------------------------------------
    localparam logic [7:0] OP_LD     = 8'h01;
    localparam logic [7:0] OP_LDN    = 8'h02;
    localparam logic [7:0] OP_LDI    = 8'h03;
    localparam logic [7:0] OP_ST     = 8'h04;
    localparam logic [7:0] OP_STN    = 8'h05;
    localparam logic [7:0] OP_S      = 8'h06;
    localparam logic [7:0] OP_R      = 8'h07;
    localparam logic [7:0] OP_AND    = 8'h08;
    localparam logic [7:0] OP_ANDN   = 8'h09;
    localparam logic [7:0] OP_ANDI   = 8'h0A;
    localparam logic [7:0] OP_OR     = 8'h0B;
    localparam logic [7:0] OP_ORN    = 8'h0C;
    localparam logic [7:0] OP_ORI    = 8'h0D;
    localparam logic [7:0] OP_XOR    = 8'h0E;
    localparam logic [7:0] OP_XORN   = 8'h0F;
    localparam logic [7:0] OP_XORI   = 8'h10;
    localparam logic [7:0] OP_NOT    = 8'h11;
    localparam logic [7:0] OP_EQU    = 8'h12;
    localparam logic [7:0] OP_F_TRIG = 8'h13;
    localparam logic [7:0] OP_R_TRIG = 8'h14;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Decode helpers
    // ------------------------------------------------------------------

    // Instructions whose result lands in CR.
    function automatic logic writes_cr(input logic [7:0] code);
        logic hit;
        hit = 1'b0;
        case (code)
            OP_LD, OP_LDN, OP_LDI,
            OP_AND, OP_ANDN, OP_ANDI,
            OP_OR, OP_ORN, OP_ORI,
            OP_XOR, OP_XORN, OP_XORI,
            OP_NOT, OP_EQU,
            OP_F_TRIG, OP_R_TRIG: hit = 1'b1;
            default:              hit = 1'b0;
        endcase
        return hit;
    endfunction

    // Instructions that always write Data Memory. The edge detectors also
    // write DM, because they keep their previous input sample there.
    function automatic logic writes_dm(input logic [7:0] code);
        logic hit;
        hit = 1'b0;
        case (code)
            OP_ST, OP_STN, OP_F_TRIG, OP_R_TRIG: hit = 1'b1;
            default:                             hit = 1'b0;
        endcase
        return hit;
    endfunction

    // S and R write DM only when CR bit 0 is set.
    function automatic logic is_set_reset(input logic [7:0] code);
        return (code == OP_S) || (code == OP_R);
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                 state_q,      state_d;
    logic [PM_ADDR_W-1:0]   pc_q,         pc_d;
    logic [PM_ADDR_W-1:0]   prog_last_q,  prog_last_d;
    logic [7:0]             instr_code_q, instr_code_d;
    logic [1:0]             dm_type_q,    dm_type_d;
    logic [DM_ADDR_W-1:0]   dm_addr_q,    dm_addr_d;
    logic [15:0]            scan_cnt_q,   scan_cnt_d;

    // The immediate operand goes straight from PM to the ALU, and only bit 0
    // of CR matters here. The remaining bits are folded into one signal so
    // that every input is seen as consumed.
    logic unused_inputs;
    assign unused_inputs = ^{pm_const, cr_out[31:1]};

    // ------------------------------------------------------------------
    // Next-state and strobe logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        prog_last_d  = prog_last_q;
        instr_code_d = instr_code_q;
        dm_type_d    = dm_type_q;
        dm_addr_d    = dm_addr_q;
        scan_cnt_d   = scan_cnt_q;
        dm_rd        = 1'b0;
        dm_we        = 1'b0;
        cr_we        = 1'b0;
        op_err       = 1'b0;
        scan_done    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                pc_d = '0;
                if (run) begin
                    prog_last_d = prog_last;
                    state_d     = ST_FETCH;
                end
            end

            // pm_addr follows pc. The ROM word appears in DECODE.
            ST_FETCH: begin
                state_d = ST_DECODE;
            end

            ST_DECODE: begin
                instr_code_d = pm_instr_code;
                dm_type_d    = pm_dm_type;
                dm_addr_d    = pm_dm_addr;
                dm_rd        = 1'b1;
                state_d      = ST_EXEC;
            end

            ST_EXEC: begin
                if (writes_cr(instr_code_q)) begin
                    cr_we = 1'b1;
                end
                if (writes_dm(instr_code_q)) begin
                    dm_we = 1'b1;
                end else if (is_set_reset(instr_code_q)) begin
                    dm_we = cr_out[0];
                end
                // Undefined codes flag an error but otherwise behave as NOP.
                if (!writes_cr(instr_code_q) && !writes_dm(instr_code_q) &&
                    !is_set_reset(instr_code_q)) begin
                    op_err = 1'b1;
                end

                // The comparison is against the value latched at scan start,
                // so changes on prog_last mid-scan cannot cut a scan short.
                if (pc_q == prog_last_q) begin
                    state_d = ST_DONE;
                end else begin
                    pc_d    = pc_q + 1'b1;
                    state_d = ST_FETCH;
                end
            end

            ST_DONE: begin
                scan_done  = 1'b1;
                scan_cnt_d = scan_cnt_q + 16'd1;
                pc_d       = '0;
                // run is sampled only here and in IDLE. Dropping it
                // mid-scan therefore lets the scan finish.
                if (run) begin
                    prog_last_d = prog_last;
                    state_d     = ST_FETCH;
                end else begin
                    state_d     = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                pc_d    = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            pc_q         <= '0;
            prog_last_q  <= '0;
            instr_code_q <= '0;
            dm_type_q    <= '0;
            dm_addr_q    <= '0;
            scan_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            prog_last_q  <= prog_last_d;
            instr_code_q <= instr_code_d;
            dm_type_q    <= dm_type_d;
            dm_addr_q    <= dm_addr_d;
            scan_cnt_q   <= scan_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // All write strobes decode from the state register. The first cycle after
    // reset is therefore IDLE, and it can never carry a leftover write.
    assign pm_addr    = pc_q;
    assign instr_code = instr_code_q;
    assign dm_type    = dm_type_q;
    assign dm_addr    = dm_addr_q;
    assign scan_cnt   = scan_cnt_q;
    assign busy       = (state_q != ST_IDLE);

endmodule
